// File: rtl/cnn_defs.sv
// Shared definitions for the CNN accelerator blocks: streaming-conv FSM
// states and the geometry/width helpers used to size the datapath.
package cnn_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } cnn_stream_state_t;

  // Number of valid window positions along one axis.
  function automatic int conv_out_dim(input int img, input int k, input int s);
    return (img - k) / s + 1;
  endfunction

  // Accumulator width that cannot overflow for k*k signed x zero-extended products.
  function automatic int acc_width(input int dw, input int k);
    return 2 * dw + 1 + $clog2(k * k);
  endfunction

endpackage

// File: rtl/cnn_stream_conv_line_buffer.sv
// cnn_line_buffer: K-1 row delay lines of IMG_W pixels feeding a KxK window
// shift register. Everything advances only when i_en is high. o_win_next is
// the window as it will look after the current pixel is shifted in, so the
// consumer can compute on it in the same cycle. Row 0 of the window is the
// oldest (top) row, column 0 the leftmost pixel; element (i,j) sits at
// o_win_next[(i*K+j)*DATA_WIDTH +: DATA_WIDTH]. Data storage is not reset.
module cnn_line_buffer #(
  parameter int DATA_WIDTH  = 8,
  parameter int IMG_W       = 28,
  parameter int KERNEL_SIZE = 3
) (
  input  logic                                          clk,
  input  logic                                          i_en,
  input  logic [DATA_WIDTH-1:0]                         i_pix,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] o_win_next
);

  localparam int K  = KERNEL_SIZE;
  localparam int DW = DATA_WIDTH;

  logic [DW-1:0] r_rows     [K-1][IMG_W];
  logic [DW-1:0] r_win      [K][K];
  logic [DW-1:0] w_tap      [K];
  logic [DW-1:0] w_win_next [K][K];

  // Vertical taps: tap j is the pixel j rows above the incoming one.
  always_comb begin
    w_tap[0] = i_pix;
    for (int j = 1; j < K; j++) begin
      w_tap[j] = r_rows[j-1][IMG_W-1];
    end
  end

  // Next window: shift every row left by one, new column enters on the right.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      for (int c = 0; c < K - 1; c++) begin
        w_win_next[i][c] = r_win[i][c+1];
      end
      w_win_next[i][K-1] = w_tap[K-1-i];
    end
  end

  // Flatten the next window for the port.
  always_comb begin
    o_win_next = '0;
    for (int i = 0; i < K; i++) begin
      for (int c = 0; c < K; c++) begin
        o_win_next[(i*K+c)*DW +: DW] = w_win_next[i][c];
      end
    end
  end

  // Advance row delay lines and window on each accepted pixel.
  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int j = 0; j < K - 1; j++) begin
        r_rows[j][0] <= w_tap[j];
        for (int p = 1; p < IMG_W; p++) begin
          r_rows[j][p] <= r_rows[j][p-1];
        end
      end
      for (int i = 0; i < K; i++) begin
        for (int c = 0; c < K; c++) begin
          r_win[i][c] <= w_win_next[i][c];
        end
      end
    end
  end

endmodule

// File: rtl/cnn_stream_conv.sv
// cnn_stream_conv: streaming KxK convolution over a raster pixel stream with
// runtime-loaded signed weights, stride, ReLU, arithmetic shift and unsigned
// saturation, producing a valid/ready result stream.
// Optional build macro CNN_STREAM_POOL2X2_EN adds 2x2/stride-2 max pooling
// of the conv results; without it no pooling logic exists.
module cnn_stream_conv
  import cnn_defs::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int IMG_W       = 28,
  parameter int IMG_H       = 28,
  parameter int KERNEL_SIZE = 3,
  parameter int STRIDE      = 1,
  parameter int OUT_SHIFT   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  w_valid,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int K      = KERNEL_SIZE;
  localparam int KK     = K * K;
  localparam int DW     = DATA_WIDTH;
  localparam int ACC_W  = acc_width(DATA_WIDTH, KERNEL_SIZE);
  localparam int CONV_W = conv_out_dim(IMG_W, KERNEL_SIZE, STRIDE);
  localparam int CONV_H = conv_out_dim(IMG_H, KERNEL_SIZE, STRIDE);
`ifdef CNN_STREAM_POOL2X2_EN
  localparam int POOL_W    = CONV_W / 2;
  localparam int POOL_H    = CONV_H / 2;
  localparam int OUT_TOTAL = POOL_W * POOL_H;
`else
  localparam int OUT_TOTAL = CONV_W * CONV_H;
`endif

  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int SW  = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int WCW = $clog2(KK);
  localparam int RCW = $clog2(OUT_TOTAL + 1);

  localparam logic [CW-1:0]  COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0]  COL_K1   = CW'(K - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0]  ROW_K1   = RW'(K - 1);
  localparam logic [SW-1:0]  STR_LAST = SW'(STRIDE - 1);
  localparam logic [WCW-1:0] WC_LAST  = WCW'(KK - 1);
  localparam logic [RCW-1:0] RC_LAST  = RCW'(OUT_TOTAL - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW){1'b0}}, {DW{1'b1}}};

  cnn_stream_state_t r_state;
  logic [WCW-1:0]    r_wcnt;
  logic signed [DW-1:0] r_w [KK];
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [SW-1:0]     r_cph;
  logic [SW-1:0]     r_rph;
  logic [RCW-1:0]    r_res_cnt;
  logic              r_pix_done;
  logic              r_res_done;
  logic              r_out_valid;
  logic              r_out_last;
  logic [DW-1:0]     r_out_data;
  logic              r_done;

  logic                    w_accept;
  logic                    w_at_pos;
  logic                    w_conv_ev;
  logic                    w_out_hs;
  logic                    w_emit;
  logic [DW-1:0]           w_emit_data;
  logic [DW-1:0]           w_conv;
  logic [KK*DW-1:0]        w_win;
  logic signed [2*DW:0]    w_prod [KK];
  logic signed [ACC_W-1:0] w_acc;

  // ReLU, arithmetic shift, then clamp to the unsigned output range.
  function automatic logic [DW-1:0] post_proc(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] y;
    logic [DW-1:0]           res;
    y = a[ACC_W-1] ? '0 : (a >>> OUT_SHIFT);
    if (y > SAT_MAX) res = '1;
    else             res = y[DW-1:0];
    return res;
  endfunction

  assign in_ready  = (r_state == RUN) && !r_pix_done && (!r_out_valid || out_ready);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;

  assign w_accept  = in_valid && in_ready;
  assign w_out_hs  = r_out_valid && out_ready;
  // A window is complete and on the stride grid; c<K-1 never qualifies, so
  // windows straddling a row wrap are never emitted.
  assign w_at_pos  = (r_row >= ROW_K1) && (r_col >= COL_K1) && (r_cph == '0) && (r_rph == '0);
  assign w_conv_ev = w_accept && w_at_pos;

  cnn_line_buffer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .IMG_W       (IMG_W),
    .KERNEL_SIZE (KERNEL_SIZE)
  ) u_line_buffer (
    .clk        (clk),
    .i_en       (w_accept),
    .i_pix      (in_data),
    .o_win_next (w_win)
  );

  // Signed weight times zero-extended pixel, both widened to product width.
  always_comb begin
    logic signed [2*DW:0] w_a;
    logic signed [2*DW:0] w_b;
    for (int i = 0; i < KK; i++) begin
      w_a       = {{(DW+1){r_w[i][DW-1]}}, r_w[i]};
      w_b       = {{DW{1'b0}}, w_win[i*DW +: DW]};
      w_prod[i] = w_a * w_b;
    end
  end

  // Sum of products over the window that the current pixel completes.
  always_comb begin
    w_acc = '0;
    for (int i = 0; i < KK; i++) begin
      w_acc = w_acc + {{(ACC_W-2*DW-1){w_prod[i][2*DW]}}, w_prod[i]};
    end
  end

  assign w_conv = post_proc(w_acc);

`ifdef CNN_STREAM_POOL2X2_EN
  localparam int CCW = (CONV_W > 1) ? $clog2(CONV_W) : 1;
  localparam int CRW = (CONV_H > 1) ? $clog2(CONV_H) : 1;
  localparam int PIW = (POOL_W > 1) ? $clog2(POOL_W) : 1;
  localparam logic [CCW-1:0] CC_LAST = CCW'(CONV_W - 1);
  localparam logic [CCW:0]   CC_LIM  = (CCW+1)'(2 * POOL_W);
  localparam logic [CRW:0]   CR_LIM  = (CRW+1)'(2 * POOL_H);

  logic [CCW-1:0] r_cc;
  logic [CRW-1:0] r_cr;
  logic [DW-1:0]  r_pbuf [POOL_W];
  logic           w_in_pool;
  logic [PIW-1:0] w_pidx;
  logic [DW-1:0]  w_pmax;

  function automatic logic [DW-1:0] max_u(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Trailing odd conv row/column fall outside the pool grid and are dropped.
  assign w_in_pool   = ({1'b0, r_cc} < CC_LIM) && ({1'b0, r_cr} < CR_LIM);
  assign w_pidx      = PIW'(r_cc >> 1);
  assign w_pmax      = max_u(r_pbuf[w_pidx], w_conv);
  assign w_emit      = w_conv_ev && w_in_pool && r_cr[0] && r_cc[0];
  assign w_emit_data = w_pmax;

  // Conv-result coordinates, restarted for every frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cc <= '0;
      r_cr <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_cc <= '0;
      r_cr <= '0;
    end else if (w_conv_ev) begin
      if (r_cc == CC_LAST) begin
        r_cc <= '0;
        r_cr <= r_cr + CRW'(1);
      end else begin
        r_cc <= r_cc + CCW'(1);
      end
    end
  end

  // Running max per pool column; seeded at the top-left of each pool window.
  always_ff @(posedge clk) begin
    if (w_conv_ev && w_in_pool) begin
      if (!r_cr[0] && !r_cc[0])    r_pbuf[w_pidx] <= w_conv;
      else if (!(r_cr[0] && r_cc[0])) r_pbuf[w_pidx] <= w_pmax;
    end
  end
`else
  assign w_emit      = w_conv_ev;
  assign w_emit_data = w_conv;
`endif

  // Weight store; contents are only meaningful after a complete load.
  always_ff @(posedge clk) begin
    if ((r_state == LOAD_W) && w_valid) r_w[r_wcnt] <= w_data;
  end

  // Control FSM with raster counters and the registered output stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_wcnt      <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_cph       <= '0;
      r_rph       <= '0;
      r_res_cnt   <= '0;
      r_pix_done  <= 1'b0;
      r_res_done  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= LOAD_W;
            r_wcnt     <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_cph      <= '0;
            r_rph      <= '0;
            r_res_cnt  <= '0;
            r_pix_done <= 1'b0;
            r_res_done <= 1'b0;
            r_out_last <= 1'b0;
          end
        end
        LOAD_W: begin
          if (w_valid) begin
            if (r_wcnt == WC_LAST) begin
              r_wcnt  <= '0;
              r_state <= RUN;
            end else begin
              r_wcnt <= r_wcnt + WCW'(1);
            end
          end
        end
        RUN: begin
          if (w_accept) begin
            if (r_col == COL_LAST) begin
              r_col <= '0;
              r_cph <= '0;
              if (r_row == ROW_LAST) begin
                r_row      <= '0;
                r_rph      <= '0;
                r_pix_done <= 1'b1;
              end else begin
                r_row <= r_row + RW'(1);
                if (r_row >= ROW_K1) r_rph <= (r_rph == STR_LAST) ? '0 : r_rph + SW'(1);
              end
            end else begin
              r_col <= r_col + CW'(1);
              if (r_col >= COL_K1) r_cph <= (r_cph == STR_LAST) ? '0 : r_cph + SW'(1);
            end
          end
          if (w_emit) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_emit_data;
            r_out_last  <= (r_res_cnt == RC_LAST);
            r_res_cnt   <= r_res_cnt + RCW'(1);
          end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
          end
          if (w_out_hs && r_out_last) r_res_done <= 1'b1;
          if (r_pix_done && (r_res_done || (w_out_hs && r_out_last))) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_stream_conv.sv
// Directed bench for cnn_stream_conv: table of frames with hand-computed
// results plus reset and mid-frame abort sequences.
module tb_cnn_stream_conv;

`ifdef CNN_STREAM_POOL2X2_EN
  localparam int A_W = 6;
`else
  localparam int A_W = 5;
`endif
  localparam int NPIX = A_W * A_W;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       w_valid = 1'b0;
  logic [7:0] w_data = '0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       out_ready = 1'b0;
  logic       sel = 1'b0;

  logic       a_in_ready, a_out_valid, a_out_last, a_busy, a_done;
  logic [7:0] a_out_data;
  logic       b_in_ready, b_out_valid, b_out_last, b_busy, b_done;
  logic [7:0] b_out_data;
  logic       m_in_ready, m_out_valid, m_out_last, m_done;
  logic [7:0] m_out_data;

  always #5 clk = ~clk;

  cnn_stream_conv #(.DATA_WIDTH(8), .IMG_W(A_W), .IMG_H(A_W), .KERNEL_SIZE(3),
                    .STRIDE(1), .OUT_SHIFT(0)) dut_a (
    .clk(clk), .reset(reset), .start(start), .w_valid(w_valid), .w_data(w_data),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_last(a_out_last), .busy(a_busy), .done(a_done));

  cnn_stream_conv #(.DATA_WIDTH(8), .IMG_W(5), .IMG_H(5), .KERNEL_SIZE(3),
                    .STRIDE(2), .OUT_SHIFT(0)) dut_b (
    .clk(clk), .reset(reset), .start(start), .w_valid(w_valid), .w_data(w_data),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .busy(b_busy), .done(b_done));

  assign m_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign m_out_valid = sel ? b_out_valid : a_out_valid;
  assign m_out_data  = sel ? b_out_data  : a_out_data;
  assign m_out_last  = sel ? b_out_last  : a_out_last;
  assign m_done      = sel ? b_done      : a_done;

  typedef struct {
    string           name;
    int              sel;
    int              rdy;
    int              pm;
    int              n;
    bit [8:0][7:0]   w;
    bit [8:0][15:0]  e;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ready_mode = 0;
  int   q_val[$];
  int   q_last[$];
  int   q_cyc[$];
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   bp_viol = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (ready_mode == 0)      out_ready = 1'b1;
    else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
    else                      out_ready = 1'b0;
  end

  always @(negedge clk) begin
    if (reset) begin
      if (m_out_valid && out_ready) begin
        q_val.push_back(int'(m_out_data));
        q_last.push_back(int'(m_out_last));
        q_cyc.push_back(cyc);
      end
      if (m_out_valid && !out_ready && m_in_ready) bp_viol++;
      if (prev_stall && (!m_out_valid || (m_out_data !== prev_data))) bp_viol++;
      prev_stall = m_out_valid && !out_ready;
      prev_data  = m_out_data;
      if (m_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pixv(input int pm, input int i);
    logic [7:0] p;
    if (pm == 0)      p = 8'd1;
    else if (pm == 1) p = i[7:0];
    else              p = 8'd255;
    return p;
  endfunction

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; w_valid = 1'b0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic load_weights(input bit [8:0][7:0] w);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      w_valid = 1'b1;
      w_data  = w[i];
      @(posedge clk); #1;
    end
    w_valid = 1'b0;
  endtask

  task automatic send_frame(input int pm, input int n);
    logic acc;
    int   guard;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = pixv(pm, i);
      guard = 0;
      acc   = 1'b0;
      while (!acc && guard < 200) begin
        @(negedge clk);
        acc = m_in_ready;
        @(posedge clk); #1;
        guard++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL send_timeout pixel=%0d in_ready=0 required=1", i);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int guard;
    do_reset();
    sel        = v.sel[0];
    ready_mode = v.rdy;
    q_val.delete(); q_last.delete(); q_cyc.delete();
    done_cnt = 0;
    bp_viol  = 0;
    load_weights(v.w);
    send_frame(v.pm, NPIX);
    guard = 0;
    while (done_cnt == 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk({v.name, "_done_seen"}, (done_cnt > 0) ? 1 : 0, 1);
    chk({v.name, "_count"}, q_val.size(), v.n);
    for (int i = 0; i < v.n; i++) begin
      if (i < q_val.size()) begin
        chk($sformatf("%s_val%0d", v.name, i), q_val[i], int'(v.e[i]));
        chk($sformatf("%s_last%0d", v.name, i), q_last[i], (i == v.n - 1) ? 1 : 0);
      end
    end
    if (q_cyc.size() > 0) chk({v.name, "_done_timing"}, done_cyc, q_cyc[q_cyc.size()-1] + 1);
    repeat (5) @(posedge clk);
    chk({v.name, "_done_once"}, done_cnt, 1);
    chk({v.name, "_backpressure"}, bp_viol, 0);
    chk({v.name, "_idle_busy"}, int'(sel ? b_busy : a_busy), 0);
  endtask

  initial begin
    vec_t v;
`ifdef CNN_STREAM_POOL2X2_EN
    v.name = "pool"; v.sel = 0; v.rdy = 0; v.pm = 1; v.n = 4;
    v.w = '0; v.w[4] = 8'd1;
    v.e = '0; v.e[0] = 16'd14; v.e[1] = 16'd16; v.e[2] = 16'd26; v.e[3] = 16'd28;
    vecs.push_back(v);
`else
    v.name = "ones"; v.sel = 0; v.rdy = 0; v.pm = 0; v.n = 9;
    for (int i = 0; i < 9; i++) begin v.w[i] = 8'd1; v.e[i] = 16'd9; end
    vecs.push_back(v);
    v.name = "ramp_center"; v.pm = 1;
    v.w = '0; v.w[4] = 8'd1;
    v.e[0] = 16'd6;  v.e[1] = 16'd7;  v.e[2] = 16'd8;
    v.e[3] = 16'd11; v.e[4] = 16'd12; v.e[5] = 16'd13;
    v.e[6] = 16'd16; v.e[7] = 16'd17; v.e[8] = 16'd18;
    vecs.push_back(v);
    v.name = "ramp_rand_ready"; v.rdy = 1;
    vecs.push_back(v);
    v.name = "saturate"; v.rdy = 0; v.pm = 2;
    for (int i = 0; i < 9; i++) begin v.w[i] = 8'd1; v.e[i] = 16'd255; end
    vecs.push_back(v);
    v.name = "relu"; v.pm = 2;
    for (int i = 0; i < 9; i++) begin v.w[i] = 8'hFF; v.e[i] = 16'd0; end
    vecs.push_back(v);
    v.name = "stride2"; v.sel = 1; v.pm = 1; v.n = 4;
    for (int i = 0; i < 9; i++) v.w[i] = 8'd1;
    v.e = '0; v.e[0] = 16'd54; v.e[1] = 16'd72; v.e[2] = 16'd144; v.e[3] = 16'd162;
    vecs.push_back(v);
`endif

    // Reset state of both instances while reset is held low.
    repeat (3) @(negedge clk);
    chk("rst_a_out_valid", int'(a_out_valid), 0);
    chk("rst_a_out_data",  int'(a_out_data),  0);
    chk("rst_a_out_last",  int'(a_out_last),  0);
    chk("rst_a_done",      int'(a_done),      0);
    chk("rst_a_busy",      int'(a_busy),      0);
    chk("rst_a_in_ready",  int'(a_in_ready),  0);
    chk("rst_b_out_valid", int'(b_out_valid), 0);
    chk("rst_b_out_data",  int'(b_out_data),  0);
    chk("rst_b_out_last",  int'(b_out_last),  0);
    chk("rst_b_done",      int'(b_done),      0);
    chk("rst_b_busy",      int'(b_busy),      0);
    chk("rst_b_in_ready",  int'(b_in_ready),  0);

    for (int t = 0; t < vecs.size(); t++) run_vec(vecs[t]);

`ifndef CNN_STREAM_POOL2X2_EN
    // Abort mid-frame with a result pending, then rerun the first frame.
    do_reset();
    sel = 1'b0;
    ready_mode = 2;
    done_cnt = 0;
    load_weights(vecs[0].w);
    chk("mid_busy_run", int'(a_busy), 1);
    send_frame(0, 13);
    @(negedge clk);
    chk("mid_pending_valid", int'(a_out_valid), 1);
    chk("mid_pending_data",  int'(a_out_data), 9);
    chk("mid_in_ready_stall", int'(a_in_ready), 0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(a_out_valid), 0);
    chk("mid_rst_out_data",  int'(a_out_data), 0);
    chk("mid_rst_busy",      int'(a_busy), 0);
    chk("mid_rst_in_ready",  int'(a_in_ready), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    ready_mode = 0;
    repeat (10) @(posedge clk);
    chk("mid_no_done", done_cnt, 0);
    v = vecs[0];
    v.name = "rerun_ones";
    run_vec(v);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
